dac_serial_rx: RTL and testbench

- Deserialiser and frame checker that sits directly downstream of the DAC serial interface, on the same clk_4M domain as the SCEn frame generator.
- Samples the serial DAC data line during each active-low SCEn window and rebuilds the parallel code word.
- Validates frame length and flags malformed frames.
- Used as a loopback monitor in FPGA builds and as the reference checker in DAC-path benches.

---
 rtl/dac_serial_rx_if.sv | 24 ++
 rtl/dac_serial_rx.sv | 146 ++++++++++++++
 tb/tb_dac_serial_rx.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/dac_serial_rx_if.sv
// Serial DAC monitor bus: SCEn/sdi toward the receiver, decoded word and
// frame statistics back out.
interface dac_serial_rx_if #(
  parameter int FRAME_LEN = 8
);
  logic                 DAC_scen;
  logic                 sdi;
  logic [FRAME_LEN-1:0] word;
  logic                 word_vld;
  logic                 frame_err;
  logic [15:0]          frame_cnt;
  logic [7:0]           err_cnt;
  logic                 link_idle;

  modport master (
    output DAC_scen, sdi,
    input  word, word_vld, frame_err, frame_cnt, err_cnt, link_idle
  );

  modport slave (
    input  DAC_scen, sdi,
    output word, word_vld, frame_err, frame_cnt, err_cnt, link_idle
  );
endinterface

// File: rtl/dac_serial_rx.sv
// Deserialiser and frame-length checker for the SCEn-framed DAC serial line.
//
// state   | meaning
// SYNC    | after reset; waits for SCEn high so a frame in flight is never decoded
// IDLE    | between frames; next SCEn-low edge captures bit 1
// SHIFT   | collecting bits of the current frame
// OVERRUN | frame exceeded FRAME_LEN bits; waits for SCEn release to flag it
module dac_serial_rx #(
  parameter int FRAME_LEN    = 8,
  parameter bit MSB_FIRST    = 1'b1,
  parameter int IDLE_TIMEOUT = 64
) (
  input logic              clk_4M,
  input logic              rst_n,
  dac_serial_rx_if.slave   bus
);

  localparam int              CW       = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0]   LAST_BIT = CW'(FRAME_LEN);
  localparam logic [15:0]     IDLE_MAX = 16'(IDLE_TIMEOUT);

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    IDLE    = 2'd1,
    SHIFT   = 2'd2,
    OVERRUN = 2'd3
  } state_t;

  state_t               state_q, state_nxt;
  logic [CW-1:0]        cnt_q, cnt_nxt;
  logic [FRAME_LEN-1:0] shift_q, shift_nxt, shift_in;
  logic [FRAME_LEN-1:0] word_q;
  logic                 good_set, bad_set;
  logic                 good_q, bad_q;
  logic                 word_vld_q, frame_err_q;
  logic [15:0]          frame_cnt_q;
  logic [7:0]           err_cnt_q;
  logic [15:0]          idle_q, idle_nxt;
  logic                 link_idle_q;
  logic                 scen;

  assign scen = bus.DAC_scen;

  always_comb begin
    if (MSB_FIRST) shift_in = {shift_q[FRAME_LEN-2:0], bus.sdi};
    else           shift_in = {bus.sdi, shift_q[FRAME_LEN-1:1]};
  end

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    shift_nxt = shift_q;
    good_set  = 1'b0;
    bad_set   = 1'b0;
    case (state_q)
      SYNC: begin
        if (scen) state_nxt = IDLE;
      end
      IDLE: begin
        if (!scen) begin
          state_nxt = SHIFT;
          shift_nxt = shift_in;
          cnt_nxt   = CW'(1);
        end
      end
      SHIFT: begin
        if (!scen) begin
          if (cnt_q == LAST_BIT) begin
            state_nxt = OVERRUN;
          end else begin
            shift_nxt = shift_in;
            cnt_nxt   = cnt_q + CW'(1);
          end
        end else begin
          // release edge decides the frame; sdi is not sampled here
          if (cnt_q == LAST_BIT) good_set = 1'b1;
          else                   bad_set  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      OVERRUN: begin
        if (scen) begin
          bad_set   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = SYNC;
    endcase
  end

  always_comb begin
    idle_nxt = idle_q;
    if (!scen)                                        idle_nxt = '0;
    else if (state_q != SYNC && idle_q != IDLE_MAX)   idle_nxt = idle_q + 16'd1;
  end

  always_ff @(posedge clk_4M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SYNC;
      cnt_q   <= '0;
      shift_q <= '0;
      good_q  <= 1'b0;
      bad_q   <= 1'b0;
      idle_q  <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      shift_q <= shift_nxt;
      good_q  <= good_set;
      bad_q   <= bad_set;
      idle_q  <= idle_nxt;
    end
  end

  // Frame result is published one edge after release; shift_q still holds the
  // closed frame here even if the next frame's first bit lands on this edge.
  always_ff @(posedge clk_4M or negedge rst_n) begin
    if (!rst_n) begin
      word_q      <= '0;
      word_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
      link_idle_q <= 1'b0;
    end else begin
      word_vld_q  <= good_q;
      frame_err_q <= bad_q;
      link_idle_q <= (idle_nxt == IDLE_MAX);
      if (good_q) begin
        word_q      <= shift_q;
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      if (bad_q && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.word      = word_q;
  assign bus.word_vld  = word_vld_q;
  assign bus.frame_err = frame_err_q;
  assign bus.frame_cnt = frame_cnt_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.link_idle = link_idle_q;

endmodule

// File: tb/tb_dac_serial_rx.sv
// Directed bench for dac_serial_rx: MSB-first instance for framing, errors and
// idle monitor; LSB-first instance for bit placement.
module tb_dac_serial_rx;

  logic clk_4M = 1'b0;
  logic rst_n  = 1'b0;

  always #5 clk_4M = ~clk_4M;

  dac_serial_rx_if #(.FRAME_LEN(8)) bus_a ();
  dac_serial_rx_if #(.FRAME_LEN(8)) bus_b ();

  dac_serial_rx #(.FRAME_LEN(8), .MSB_FIRST(1'b1), .IDLE_TIMEOUT(64)) dut_a (
    .clk_4M (clk_4M),
    .rst_n  (rst_n),
    .bus    (bus_a.slave)
  );

  dac_serial_rx #(.FRAME_LEN(8), .MSB_FIRST(1'b0), .IDLE_TIMEOUT(64)) dut_b (
    .clk_4M (clk_4M),
    .rst_n  (rst_n),
    .bus    (bus_b.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int vld_seen = 0;
  int err_seen = 0;
  int pc0 = 0, pc1 = 0;
  logic [7:0] pw0 = '0, pw1 = '0;
  logic rel_vld, post_vld;
  logic [7:0] pat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk_4M) cyc++;

  always @(negedge clk_4M) begin
    if (rst_n) begin
      if (bus_a.word_vld) begin
        vld_seen++;
        pc0 = pc1;
        pc1 = cyc;
        pw0 = pw1;
        pw1 = bus_a.word;
      end
      if (bus_a.frame_err) err_seen++;
    end
  end

  task automatic step_a(input logic s, input logic d);
    bus_a.DAC_scen = s;
    bus_a.sdi      = d;
    @(posedge clk_4M);
    #1;
  endtask

  task automatic step_b(input logic s, input logic d);
    bus_b.DAC_scen = s;
    bus_b.sdi      = d;
    @(posedge clk_4M);
    #1;
  endtask

  // Sends len bits of data MSB first (bits beyond 8 are zero), then gap high cycles.
  task automatic send_frame(input logic [7:0] data, input int len, input int gap);
    for (int i = 0; i < len; i++) step_a(1'b0, (i < 8) ? data[7-i] : 1'b0);
    for (int g = 0; g < gap; g++) begin
      step_a(1'b1, 1'b0);
      if (g == 0) rel_vld  = bus_a.word_vld;
      if (g == 1) post_vld = bus_a.word_vld;
    end
  endtask

  initial begin
    bus_a.DAC_scen = 1'b1;
    bus_a.sdi      = 1'b0;
    bus_b.DAC_scen = 1'b1;
    bus_b.sdi      = 1'b0;
    repeat (3) step_a(1'b1, 1'b0);
    chk("rst_word", 32'(bus_a.word), 32'h0);
    chk("rst_vld", 32'(bus_a.word_vld), 32'h0);
    chk("rst_ferr", 32'(bus_a.frame_err), 32'h0);
    chk("rst_fcnt", 32'(bus_a.frame_cnt), 32'h0);
    chk("rst_ecnt", 32'(bus_a.err_cnt), 32'h0);
    chk("rst_idle", 32'(bus_a.link_idle), 32'h0);

    // reset released during bit 4 of a frame already on the wire
    step_a(1'b0, 1'b1);
    step_a(1'b0, 1'b0);
    step_a(1'b0, 1'b1);
    rst_n = 1'b1;
    step_a(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step_a(1'b0, 1'(i % 2));
    repeat (8) step_a(1'b1, 1'b0);
    chk("sync_vld", 32'(vld_seen), 32'd0);
    chk("sync_err", 32'(err_seen), 32'd0);
    chk("sync_fcnt", 32'(bus_a.frame_cnt), 32'd0);

    for (int n = 1; n <= 4; n++) begin
      send_frame(8'hA5, 8, 8);
      if (n == 1) begin
        chk("lat_release", 32'(rel_vld), 32'd0);
        chk("lat_next", 32'(post_vld), 32'd1);
      end
      chk("std_word", 32'(bus_a.word), 32'hA5);
      chk("std_fcnt", 32'(bus_a.frame_cnt), 32'(n));
    end
    chk("std_vld_count", 32'(vld_seen), 32'd4);
    chk("std_err_count", 32'(err_seen), 32'd0);

    send_frame(8'h3F, 5, 8);
    send_frame(8'h0F, 11, 8);
    chk("bad_pulses", 32'(err_seen), 32'd2);
    chk("bad_ecnt", 32'(bus_a.err_cnt), 32'd2);
    chk("bad_word", 32'(bus_a.word), 32'hA5);
    chk("bad_fcnt", 32'(bus_a.frame_cnt), 32'd4);

    send_frame(8'h3C, 8, 1);
    send_frame(8'hC3, 8, 8);
    chk("b2b_word0", 32'(pw0), 32'h3C);
    chk("b2b_word1", 32'(pw1), 32'hC3);
    chk("b2b_spacing", 32'(pc1 - pc0), 32'd9);
    chk("b2b_fcnt", 32'(bus_a.frame_cnt), 32'd6);

    send_frame(8'hA5, 8, 63);
    chk("idle_63", 32'(bus_a.link_idle), 32'd0);
    step_a(1'b1, 1'b0);
    chk("idle_64", 32'(bus_a.link_idle), 32'd1);
    repeat (5) step_a(1'b1, 1'b0);
    chk("idle_hold", 32'(bus_a.link_idle), 32'd1);
    step_a(1'b0, 1'b0);
    chk("idle_drop", 32'(bus_a.link_idle), 32'd0);
    repeat (7) step_a(1'b0, 1'b0);
    repeat (8) step_a(1'b1, 1'b0);
    chk("zero_word", 32'(bus_a.word), 32'h00);
    chk("zero_fcnt", 32'(bus_a.frame_cnt), 32'd8);

    repeat (252) send_frame(8'hFF, 3, 1);
    repeat (3) step_a(1'b1, 1'b0);
    chk("sat_254", 32'(bus_a.err_cnt), 32'd254);
    send_frame(8'hFF, 3, 3);
    chk("sat_255", 32'(bus_a.err_cnt), 32'd255);
    repeat (47) send_frame(8'hFF, 3, 1);
    repeat (3) step_a(1'b1, 1'b0);
    chk("sat_hold", 32'(bus_a.err_cnt), 32'd255);
    chk("sat_pulses", 32'(err_seen), 32'd302);
    chk("sat_fcnt", 32'(bus_a.frame_cnt), 32'd8);

    pat = 8'h01;
    for (int i = 0; i < 8; i++) step_b(1'b0, pat[i]);
    repeat (3) step_b(1'b1, 1'b0);
    chk("lsb_word01", 32'(bus_b.word), 32'h01);
    chk("lsb_fcnt1", 32'(bus_b.frame_cnt), 32'd1);
    pat = 8'h53;
    for (int i = 0; i < 8; i++) step_b(1'b0, pat[i]);
    repeat (3) step_b(1'b1, 1'b0);
    chk("lsb_word53", 32'(bus_b.word), 32'h53);
    chk("lsb_fcnt2", 32'(bus_b.frame_cnt), 32'd2);
    chk("lsb_ecnt", 32'(bus_b.err_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
